iq_word_packer: RTL and testbench

IQ_WORD_PACKER -- requirements
Module: iq_word_packer

---
 rtl/sdr_pkg.sv | 29 ++
 rtl/sat_counter.sv | 32 +++
 rtl/iq_word_packer.sv | 170 +++++++++++++++++
 tb/tb_iq_word_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// Shared SDR stream definitions: sample/word widths, frame sync marker and
// IQ packing helpers used by the word packer.
package sdr_pkg;

  localparam logic [15:0] SDR_HDR_SYNC  = 16'hA5C3;
  localparam int          SDR_IQ_W      = 8;
  localparam int          FT_DATA_WIDTH = 32;
  localparam int          SDR_WORD_W    = FT_DATA_WIDTH;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

  // Earlier pair occupies the low half so byte 0 is always the first I sample.
  function automatic logic [SDR_WORD_W-1:0] pack_word(
    input logic [SDR_IQ_W-1:0] i0,
    input logic [SDR_IQ_W-1:0] q0,
    input logic [SDR_IQ_W-1:0] i1,
    input logic [SDR_IQ_W-1:0] q1
  );
    return {q1, i1, q0, i0};
  endfunction

  function automatic logic [SDR_WORD_W-1:0] hdr_word(input logic [15:0] seq);
    return {SDR_HDR_SYNC, seq};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] r_value;

  // Count register: clear wins, otherwise step until saturated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= {W{1'b0}};
    end else if (clr) begin
      r_value <= {W{1'b0}};
    end else if (inc && (r_value != MAX)) begin
      r_value <= r_value + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_value <= r_value;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/iq_word_packer.sv
// Packs pairs of 8-bit IQ samples into 32-bit FIFO words, dropping and counting
// words that meet a full FIFO. Define IQ_PACK_HDR_EN to insert frame headers.
module iq_word_packer
  import sdr_pkg::*;
#(
  parameter int FRAME_WORDS = 1024,
  parameter int OVF_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [SDR_IQ_W-1:0]   in_i,
  input  logic [SDR_IQ_W-1:0]   in_q,
  input  logic                  fifo_full,
  output logic                  fifo_wrreq,
  output logic [SDR_WORD_W-1:0] fifo_wdata,
  output logic                  wr_incomming,
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
  output logic [OVF_W-1:0]      ovf_count
);

  if ((FRAME_WORDS < 2) || (FRAME_WORDS > 65535)) begin : g_frame_words_range
    $error("iq_word_packer: FRAME_WORDS must be within 2..65535");
  end

  pack_state_e           r_state;
  pack_state_e           w_state_nxt;
  logic [SDR_IQ_W-1:0]   r_i0;
  logic [SDR_IQ_W-1:0]   r_q0;
  logic                  r_wrreq;
  logic [SDR_WORD_W-1:0] r_wdata;
  logic                  r_wr_inc;
  logic                  r_sticky;

  logic                  w_pair0;
  logic                  w_complete;
  logic                  w_data_wr;
  logic                  w_data_drop;
  logic                  w_hdr_wr;
  logic                  w_hdr_drop;
  logic [SDR_WORD_W-1:0] w_hdr_word;
  logic                  w_drop;
  logic                  w_wrreq_nxt;
  logic [SDR_WORD_W-1:0] w_wdata_nxt;
  logic                  w_wr_inc_nxt;
  logic                  w_sticky_nxt;

  assign w_pair0     = en & in_valid & (r_state == ST_EMPTY);
  assign w_complete  = en & in_valid & (r_state == ST_HALF);
  assign w_data_wr   = w_complete & ~fifo_full;
  assign w_data_drop = w_complete & fifo_full;
  assign w_drop      = w_data_drop | w_hdr_drop;

`ifdef IQ_PACK_HDR_EN
  localparam logic [15:0] LAST_WORD = 16'(FRAME_WORDS - 1);

  logic [15:0] r_word_cnt;
  logic [15:0] r_seq;
  logic        w_hdr_attempt;

  // A frame starts whenever the data-word counter is back at zero.
  assign w_hdr_attempt = w_pair0 & (r_word_cnt == 16'd0);
  assign w_hdr_wr      = w_hdr_attempt & ~fifo_full;
  assign w_hdr_drop    = w_hdr_attempt & fifo_full;
  assign w_hdr_word    = hdr_word(r_seq);

  // Frame position and header sequence; disabling restarts the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_cnt <= 16'd0;
      r_seq      <= 16'd0;
    end else begin
      if (!en) begin
        r_word_cnt <= 16'd0;
      end else if (w_complete) begin
        r_word_cnt <= (r_word_cnt == LAST_WORD) ? 16'd0 : r_word_cnt + 16'd1;
      end else begin
        r_word_cnt <= r_word_cnt;
      end
      r_seq <= w_hdr_attempt ? r_seq + 16'd1 : r_seq;
    end
  end
`else
  assign w_hdr_wr   = 1'b0;
  assign w_hdr_drop = 1'b0;
  assign w_hdr_word = {SDR_WORD_W{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: each accepted pair toggles word alignment, disable realigns.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = ST_EMPTY;
    end else if (in_valid) begin
      case (r_state)
        ST_EMPTY: w_state_nxt = ST_HALF;
        ST_HALF:  w_state_nxt = ST_EMPTY;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Next output values for the registered FIFO side and overflow status.
  always_comb begin
    w_wrreq_nxt = w_data_wr | w_hdr_wr;
    if (w_data_wr) begin
      w_wdata_nxt = pack_word(r_i0, r_q0, in_i, in_q);
    end else if (w_hdr_wr) begin
      w_wdata_nxt = w_hdr_word;
    end else begin
      w_wdata_nxt = r_wdata;
    end
    w_wr_inc_nxt = (w_state_nxt == ST_HALF) | w_wrreq_nxt;
    if (ovf_clr) begin
      w_sticky_nxt = 1'b0;
    end else if (w_drop) begin
      w_sticky_nxt = 1'b1;
    end else begin
      w_sticky_nxt = r_sticky;
    end
  end

  // Output registers and the held first pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i0     <= {SDR_IQ_W{1'b0}};
      r_q0     <= {SDR_IQ_W{1'b0}};
      r_wrreq  <= 1'b0;
      r_wdata  <= {SDR_WORD_W{1'b0}};
      r_wr_inc <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_i0     <= w_pair0 ? in_i : r_i0;
      r_q0     <= w_pair0 ? in_q : r_q0;
      r_wrreq  <= w_wrreq_nxt;
      r_wdata  <= w_wdata_nxt;
      r_wr_inc <= w_wr_inc_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  sat_counter #(
    .W (OVF_W)
  ) u_ovf_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_drop),
    .clr     (ovf_clr),
    .value   (ovf_count)
  );

  assign fifo_wrreq   = r_wrreq;
  assign fifo_wdata   = r_wdata;
  assign wr_incomming = r_wr_inc;
  assign ovf_sticky   = r_sticky;

endmodule

// File: tb/tb_iq_word_packer.sv
// Self-checking bench for iq_word_packer: directed scenarios plus random
// traffic against a stream-level reference model (headers with IQ_PACK_HDR_EN).
module tb_iq_word_packer;

  localparam int FW   = 2;
  localparam int OW   = 10;
  localparam int MAXC = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_i = 8'h00;
  logic [7:0]    in_q = 8'h00;
  logic          fifo_full = 1'b0;
  logic          fifo_wrreq;
  logic [31:0]   fifo_wdata;
  logic          wr_incomming;
  logic          ovf_clr = 1'b0;
  logic          ovf_sticky;
  logic [OW-1:0] ovf_count;

  iq_word_packer #(
    .FRAME_WORDS (FW),
    .OVF_W       (OW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .in_valid     (in_valid),
    .in_i         (in_i),
    .in_q         (in_q),
    .fifo_full    (fifo_full),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_wdata   (fifo_wdata),
    .wr_incomming (wr_incomming),
    .ovf_clr      (ovf_clr),
    .ovf_sticky   (ovf_sticky),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: stream-level view of held pair, frame position, drops.
  bit          m_have;
  logic [7:0]  m_i0, m_q0;
  int          m_words;
  int          m_seq;
  int          m_cnt;
  bit          m_sticky;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0; m_i0 = 8'h00; m_q0 = 8'h00;
    m_words = 0; m_seq = 0; m_cnt = 0; m_sticky = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_wrreq", fifo_wrreq, 1'b0);
    chk("rst_wdata", fifo_wdata, 32'h0);
    chk("rst_wr_inc", wr_incomming, 1'b0);
    chk("rst_cnt", ovf_count, 0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic cyc(input bit e, input bit v, input logic [7:0] i, input logic [7:0] q,
                     input bit full, input bit clr);
    bit          e_wr;
    bit          dropped;
    logic [31:0] e_data;
    en = e; in_valid = v; in_i = i; in_q = q; fifo_full = full; ovf_clr = clr;
    e_wr = 1'b0; dropped = 1'b0; e_data = 32'h0;
    if (!e) begin
      m_have = 1'b0;
      m_words = 0;
    end else if (v) begin
      if (!m_have) begin
`ifdef IQ_PACK_HDR_EN
        if ((m_words % FW) == 0) begin
          if (full) dropped = 1'b1;
          else begin e_wr = 1'b1; e_data = {16'hA5C3, 16'(m_seq)}; end
          m_seq = (m_seq + 1) % 65536;
        end
`endif
        m_have = 1'b1; m_i0 = i; m_q0 = q;
      end else begin
        if (full) dropped = 1'b1;
        else begin e_wr = 1'b1; e_data = {q, i, m_q0, m_i0}; end
        m_words++;
        m_have = 1'b0;
      end
    end
    if (clr) begin
      m_cnt = 0; m_sticky = 1'b0;
    end else if (dropped) begin
      if (m_cnt < MAXC) m_cnt++;
      m_sticky = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("wrreq", fifo_wrreq, e_wr);
    if (e_wr) chk("wdata", fifo_wdata, e_data);
    chk("wr_inc", wr_incomming, m_have || e_wr);
    chk("ovf_count", ovf_count, m_cnt);
    chk("ovf_sticky", ovf_sticky, m_sticky);
    if (fifo_wrreq === 1'b1) got_q.push_back(fifo_wdata);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) chk(tag, got_q[k], exp_q[k]);
  endtask

  initial begin
    do_reset();

    // Four back-to-back pairs.
    got_q.delete();
    cyc(1, 1, 8'h01, 8'h02, 0, 0);
    cyc(1, 1, 8'h03, 8'h04, 0, 0);
    cyc(1, 1, 8'h05, 8'h06, 0, 0);
    cyc(1, 1, 8'h07, 8'h08, 0, 0);
    chk("s1_wr_inc_last", wr_incomming, 1'b1);
    cyc(1, 0, 8'h00, 8'h00, 0, 0);
`ifdef IQ_PACK_HDR_EN
    exp_q = {32'hA5C30000, 32'h04030201, 32'h08070605};
`else
    exp_q = {32'h04030201, 32'h08070605};
`endif
    check_got("s1");

    // Drop on full, alignment preserved.
    do_reset();
    got_q.delete();
    cyc(1, 1, 8'h11, 8'h12, 0, 0);
    cyc(1, 1, 8'h13, 8'h14, 1, 0);
    chk("s2_cnt", ovf_count, 1);
    chk("s2_sticky", ovf_sticky, 1'b1);
    cyc(1, 1, 8'h21, 8'h22, 0, 0);
    cyc(1, 1, 8'h23, 8'h24, 0, 0);
    cyc(1, 0, 8'h00, 8'h00, 0, 0);
`ifdef IQ_PACK_HDR_EN
    exp_q = {32'hA5C30000, 32'h24232221};
`else
    exp_q = {32'h24232221};
`endif
    check_got("s2");

    // Disable discards the held pair.
    do_reset();
    got_q.delete();
    cyc(1, 1, 8'h55, 8'h66, 0, 0);
    cyc(0, 0, 8'h00, 8'h00, 0, 0);
    cyc(1, 1, 8'hAA, 8'hBB, 0, 0);
    cyc(1, 1, 8'hCC, 8'hDD, 0, 0);
    cyc(1, 0, 8'h00, 8'h00, 0, 0);
`ifdef IQ_PACK_HDR_EN
    exp_q = {32'hA5C30000, 32'hA5C30001, 32'hDDCCBBAA};
`else
    exp_q = {32'hDDCCBBAA};
`endif
    check_got("s3");

    // Saturation, then clear colliding with a drop.
    do_reset();
    for (int k = 0; k < MAXC + 5; k++) begin
      cyc(1, 1, 8'($urandom), 8'($urandom), 0, 0);
      cyc(1, 1, 8'($urandom), 8'($urandom), 1, 0);
    end
    chk("s4_sat", ovf_count, MAXC);
    cyc(1, 1, 8'h01, 8'h02, 0, 0);
    cyc(1, 1, 8'h03, 8'h04, 1, 0);
    chk("s4_sat_hold", ovf_count, MAXC);
    chk("s4_sticky", ovf_sticky, 1'b1);
    cyc(1, 1, 8'h05, 8'h06, 0, 0);
    cyc(1, 1, 8'h07, 8'h08, 1, 1);
    chk("s4_clr_cnt", ovf_count, 0);
    chk("s4_clr_sticky", ovf_sticky, 1'b0);

`ifdef IQ_PACK_HDR_EN
    // Frame headers with two data words per frame.
    do_reset();
    got_q.delete();
    for (int k = 0; k < 6; k++) cyc(1, 1, 8'(2 * k + 1), 8'(2 * k + 2), 0, 0);
    cyc(1, 0, 8'h00, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 8'h00, 0, 0);
    exp_q = {32'hA5C30000, 32'h04030201, 32'h08070605, 32'hA5C30001, 32'h0C0B0A09};
    check_got("s5_hdr");
`endif

    // Reset while half a word is held.
    do_reset();
    cyc(1, 1, 8'h31, 8'h32, 0, 0);
    chk("s6_half", wr_incomming, 1'b1);
    do_reset();
    got_q.delete();
    cyc(1, 1, 8'h41, 8'h42, 0, 0);
    cyc(1, 1, 8'h43, 8'h44, 0, 0);
    cyc(1, 0, 8'h00, 8'h00, 0, 0);
`ifdef IQ_PACK_HDR_EN
    exp_q = {32'hA5C30000, 32'h44434241};
`else
    exp_q = {32'h44434241};
`endif
    check_got("s6");

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
          8'($urandom), 8'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
